// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between CPU core and host load/dump port
module mem_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 8,
  parameter int RD_LAT     = 1,
  parameter int STREAK_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    CPUstate,
  input  logic          cpu_req_rd,
  input  logic          cpu_req_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ready,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic [DW-1:0] host_rdata,
  output logic          host_ack,
  output logic          host_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int SW = $clog2(STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_TOP = SW'(STREAK_MAX);
  localparam logic [2:0]    LAT        = 3'(RD_LAT);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_WAIT, S_DONE} state_t;

  state_t        r_state;
  logic [SW-1:0] r_streak;
  logic [2:0]    r_cnt;
  logic          r_owner_host;
  logic          r_err;

  logic w_cpu_elig;
  logic w_host_elig;
  logic w_host_win;
  logic w_cpu_win;
  logic w_host_refuse;

  assign w_cpu_elig    = (CPUstate == 2'b11) && (cpu_req_rd || cpu_req_wr);
  assign w_host_elig   = host_req && (CPUstate != 2'b00);
  // CPU has priority unless the host has already waited out a full streak
  assign w_host_win    = w_host_elig && (!w_cpu_elig || (r_streak == STREAK_TOP));
  assign w_cpu_win     = w_cpu_elig && !w_host_win;
  assign w_host_refuse = host_we && (CPUstate == 2'b10);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_streak     <= '0;
      r_cnt        <= '0;
      r_owner_host <= 1'b0;
      r_err        <= 1'b0;
      cpu_ready    <= 1'b0;
      host_ack     <= 1'b0;
      host_err     <= 1'b0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_rdata    <= '0;
      host_rdata   <= '0;
    end else begin
      cpu_ready <= 1'b0;
      host_ack  <= 1'b0;
      host_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_host_win) begin
            r_owner_host <= 1'b1;
            r_err        <= w_host_refuse;
            r_streak     <= '0;
            mem_en       <= 1'b1;
            mem_we       <= host_we && !w_host_refuse;
            mem_addr     <= host_addr;
            mem_wdata    <= host_wdata;
            r_state      <= S_ACC;
          end else if (w_cpu_win) begin
            r_owner_host <= 1'b0;
            r_err        <= 1'b0;
            if (!host_req)
              r_streak <= '0;
            else if (r_streak != STREAK_TOP)
              r_streak <= r_streak + 1'b1;
            mem_en       <= 1'b1;
            mem_we       <= cpu_req_wr;
            mem_addr     <= cpu_addr;
            mem_wdata    <= cpu_wdata;
            r_state      <= S_ACC;
          end
        end
        S_ACC: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (mem_we) begin
            cpu_ready <= !r_owner_host;
            host_ack  <= r_owner_host;
            host_err  <= r_owner_host && r_err;
            r_state   <= S_DONE;
          end else begin
            r_cnt   <= LAT;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            if (r_owner_host)
              host_rdata <= mem_rdata;
            else
              cpu_rdata  <= mem_rdata;
            cpu_ready <= !r_owner_host;
            host_ack  <= r_owner_host;
            host_err  <= r_owner_host && r_err;
            r_state   <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench for mem_arbiter with a latency-modelled RAM
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int RD_LAT = 3;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    CPUstate;
  logic          cpu_req_rd, cpu_req_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ready;
  logic          host_req, host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic [DW-1:0] host_rdata;
  logic          host_ack, host_err;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STREAK_MAX(SMAX)) dut (
    .clk(clk), .rst(rst), .CPUstate(CPUstate),
    .cpu_req_rd(cpu_req_rd), .cpu_req_wr(cpu_req_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
    .host_err(host_err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // RAM: read data appears RD_LAT cycles after the enable cycle
  logic [DW-1:0] ram [0:255];
  logic [DW-1:0] rd_pipe [0:RD_LAT-1];

  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr[7:0]] <= mem_wdata;
    if (mem_en) rd_pipe[0] <= ram[mem_addr[7:0]];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drop_all;
    cpu_req_rd = 1'b0;
    cpu_req_wr = 1'b0;
    host_req   = 1'b0;
    host_we    = 1'b0;
  endtask

  task automatic host_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [DW-1:0] exp_rd, input logic exp_err);
    bit seen;
    seen = 0;
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (host_ack) seen = 1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL host_access_timeout addr=%h got no ack want ack", a);
    end else begin
      n_checks++;
      if (host_err !== exp_err) begin
        n_fail++;
        $display("FAIL host_access_err addr=%h got %b want %b", a, host_err, exp_err);
      end
      if (!we) begin
        n_checks++;
        if (host_rdata !== exp_rd) begin
          n_fail++;
          $display("FAIL host_access_rdata addr=%h got %h want %h", a, host_rdata, exp_rd);
        end
      end
    end
    drop_all();
    tick();
  endtask

  task automatic test_reset;
    n_checks++;
    if ({cpu_ready, host_ack, host_err, mem_en, mem_we, mem_addr, mem_wdata, cpu_rdata, host_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h want 0",
               {cpu_ready, host_ack, host_err, mem_en, mem_we, mem_addr, mem_wdata, cpu_rdata, host_rdata});
    end
  endtask

  task automatic test_in_load;
    bit bad;
    CPUstate = 2'b01;
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0003; host_wdata = 8'hA5;
    cpu_req_rd = 1'b1; cpu_addr = 16'h0010;
    tick();
    n_checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 16'h0003, 8'hA5}) begin
      n_fail++;
      $display("FAIL in_load_acc got en=%b we=%b addr=%h wd=%h want 1 1 0003 a5", mem_en, mem_we, mem_addr, mem_wdata);
    end
    tick();
    n_checks++;
    if ({host_ack, host_err, cpu_ready} !== 3'b100) begin
      n_fail++;
      $display("FAIL in_load_ack got ack=%b err=%b rdy=%b want 1 0 0", host_ack, host_err, cpu_ready);
    end
    host_req = 1'b0; host_we = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cpu_ready || mem_en) bad = 1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL in_load_cpu_ignored got cpu activity=1 want 0");
    end
    drop_all();
    tick();
    host_access(1'b1, 16'h0020, 8'h7E, 8'h00, 1'b0);
    host_access(1'b1, 16'h0010, 8'h3C, 8'h00, 1'b0);
  endtask

  task automatic test_check_refusal;
    bit saw_we, early;
    CPUstate = 2'b10;
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0003; host_wdata = 8'h5A;
    saw_we = 0; early = 0;
    for (int i = 1; i <= 2 + RD_LAT; i++) begin
      tick();
      if (mem_we) saw_we = 1;
      if (i < 2 + RD_LAT && host_ack) early = 1;
    end
    n_checks++;
    if ({host_ack, host_err, host_rdata} !== {1'b1, 1'b1, 8'hA5}) begin
      n_fail++;
      $display("FAIL check_refuse_ack got ack=%b err=%b rd=%h want 1 1 a5", host_ack, host_err, host_rdata);
    end
    n_checks++;
    if (saw_we || early) begin
      n_fail++;
      $display("FAIL check_refuse_nowrite got we_seen=%b early=%b want 0 0", saw_we, early);
    end
    drop_all();
    tick();
    n_checks++;
    if ({host_ack, host_err} !== 2'b00) begin
      n_fail++;
      $display("FAIL check_refuse_pulse got ack=%b err=%b want 0 0", host_ack, host_err);
    end
    host_access(1'b0, 16'h0003, 8'h00, 8'hA5, 1'b0);
  endtask

  task automatic test_run_read;
    bit early;
    CPUstate = 2'b11;
    cpu_req_rd = 1'b1; cpu_addr = 16'h0020;
    early = 0;
    for (int i = 1; i <= 2 + RD_LAT; i++) begin
      tick();
      if (i < 2 + RD_LAT && cpu_ready) early = 1;
    end
    n_checks++;
    if ({cpu_ready, host_ack, cpu_rdata} !== {1'b1, 1'b0, 8'h7E} || early) begin
      n_fail++;
      $display("FAIL run_read_latency got rdy=%b ack=%b rd=%h early=%b want 1 0 7e 0",
               cpu_ready, host_ack, cpu_rdata, early);
    end
    drop_all();
    tick();
  endtask

  task automatic test_streak;
    int cnt, rounds;
    int counts [2];
    bit both, bad_data;
    CPUstate = 2'b11;
    cpu_req_rd = 1'b1; cpu_addr = 16'h0010;
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0003;
    cnt = 0; rounds = 0; both = 0; bad_data = 0;
    counts[0] = -1; counts[1] = -1;
    for (int i = 0; i < 200 && rounds < 2; i++) begin
      tick();
      if (cpu_ready && host_ack) both = 1;
      if (cpu_ready) begin
        cnt++;
        if (cpu_rdata !== 8'h3C) bad_data = 1;
      end
      if (host_ack) begin
        if (host_rdata !== 8'hA5) bad_data = 1;
        counts[rounds] = cnt;
        rounds++;
        cnt = 0;
      end
    end
    n_checks++;
    if (rounds != 2) begin
      n_fail++;
      $display("FAIL streak_timeout got %0d host grants want 2", rounds);
    end
    n_checks++;
    if (counts[0] != SMAX) begin
      n_fail++;
      $display("FAIL streak_first got %0d cpu grants want %0d", counts[0], SMAX);
    end
    n_checks++;
    if (counts[1] != SMAX) begin
      n_fail++;
      $display("FAIL streak_cleared got %0d cpu grants want %0d", counts[1], SMAX);
    end
    n_checks++;
    if (both || bad_data) begin
      n_fail++;
      $display("FAIL streak_pulses got overlap=%b bad_data=%b want 0 0", both, bad_data);
    end
    drop_all();
    tick();
  endtask

  task automatic test_rdwr_both;
    CPUstate = 2'b11;
    cpu_req_rd = 1'b1; cpu_req_wr = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 8'h11;
    tick();
    n_checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 16'h0040, 8'h11}) begin
      n_fail++;
      $display("FAIL rdwr_write got en=%b we=%b addr=%h wd=%h want 1 1 0040 11", mem_en, mem_we, mem_addr, mem_wdata);
    end
    tick();
    n_checks++;
    if (cpu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rdwr_ready got %b want 1", cpu_ready);
    end
    drop_all();
    tick();
    cpu_req_rd = 1'b1; cpu_addr = 16'h0040;
    for (int i = 0; i < 2 + RD_LAT; i++) tick();
    n_checks++;
    if ({cpu_ready, cpu_rdata} !== {1'b1, 8'h11}) begin
      n_fail++;
      $display("FAIL rdwr_readback got rdy=%b rd=%h want 1 11", cpu_ready, cpu_rdata);
    end
    drop_all();
    tick();
  endtask

  task automatic test_back_to_back;
    int t0, t1, cyc;
    CPUstate = 2'b11;
    cpu_req_wr = 1'b1; cpu_addr = 16'h0050; cpu_wdata = 8'h22;
    t0 = -1; t1 = -1;
    for (cyc = 0; cyc < 20 && t1 < 0; cyc++) begin
      tick();
      if (cpu_ready) begin
        if (t0 < 0) t0 = cyc; else t1 = cyc;
      end
    end
    n_checks++;
    if (t1 < 0 || (t1 - t0) != 3) begin
      n_fail++;
      $display("FAIL back_to_back_write_gap got %0d want 3", t1 - t0);
    end
    drop_all();
    tick();
  endtask

  task automatic test_reset_mid_read;
    bit bad;
    CPUstate = 2'b11;
    cpu_req_rd = 1'b1; cpu_addr = 16'h0010;
    tick();
    tick();
    rst = 1'b0;
    drop_all();
    tick();
    n_checks++;
    if ({cpu_ready, host_ack, host_err, mem_en, mem_we, mem_addr, mem_wdata, cpu_rdata, host_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_read_outputs got %h want 0",
               {cpu_ready, host_ack, host_err, mem_en, mem_we, mem_addr, mem_wdata, cpu_rdata, host_rdata});
    end
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cpu_ready || mem_en) bad = 1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL reset_mid_read_noack got activity=1 want 0");
    end
    cpu_req_rd = 1'b1; cpu_addr = 16'h0040;
    tick();
    n_checks++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0040}) begin
      n_fail++;
      $display("FAIL reset_mid_read_idle got en=%b we=%b addr=%h want 1 0 0040", mem_en, mem_we, mem_addr);
    end
    for (int i = 1; i < 2 + RD_LAT; i++) tick();
    n_checks++;
    if ({cpu_ready, cpu_rdata} !== {1'b1, 8'h11}) begin
      n_fail++;
      $display("FAIL reset_mid_read_after got rdy=%b rd=%h want 1 11", cpu_ready, cpu_rdata);
    end
    drop_all();
    tick();
  endtask

  initial begin
    rst = 1'b0;
    CPUstate = 2'b00;
    drop_all();
    cpu_addr = '0; cpu_wdata = '0; host_addr = '0; host_wdata = '0;
    tick();
    tick();
    test_reset();
    rst = 1'b1;
    tick();
    test_in_load();
    test_check_refusal();
    test_run_read();
    test_streak();
    test_rdwr_both();
    test_back_to_back();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
